// File: rtl/pwm_pkg.sv
// Shared definitions for the multilevel-inverter PWM peripheral:
// carrier run-control state encoding and common width defaults.
package pwm_pkg;
  localparam int DIV_W_DEF = 16;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_RUN       = 3'd2,
    ST_STOP_WAIT = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;
endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop level synchroniser for asynchronous inputs.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/carrier_seq_ctrl.sv
// Run-control sequencer for the level-shifted carrier generator: arm/run/stop/fault
// FSM, peak-synchronous freq_div double buffering and per-period sample requests.
module carrier_seq_ctrl
  import pwm_pkg::*;
#(
  parameter int DIV_W      = DIV_W_DEF,
  parameter int MIN_DIV    = 4,
  parameter int ARM_CYCLES = 8,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             fault_in,
  input  logic             fault_clr,
  input  logic             sync_pulse,
  output logic             gen_enable,
  output logic [DIV_W-1:0] gen_freq_div,
  output logic             mod_req,
  output logic             upd_done,
  output logic             upd_pending,
  output logic [2:0]       state_o,
  output logic             fault_latched,
  output logic [CNT_W-1:0] period_cnt
);
  localparam int AW = $clog2(ARM_CYCLES + 1);

  state_t           state, state_nx;
  logic             fault_s;
  logic [AW-1:0]    arm_cnt;
  logic [DIV_W-1:0] shadow, wr_val;
  logic             run_like, buffered, run_sync, arm_done, start_acc, commit;

  sync_2ff #(.W(1)) u_fault_sync (
    .clk (clk),
    .rst (rst),
    .d   (fault_in),
    .q   (fault_s)
  );

  assign wr_val    = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
  assign run_like  = (state == ST_RUN) || (state == ST_STOP_WAIT);
  // While the carrier is armed or running, writes must wait for a peak
  assign buffered  = run_like || (state == ST_ARM);
  assign run_sync  = run_like && sync_pulse;
  assign arm_done  = (state == ST_ARM) && (state_nx == ST_RUN);
  assign start_acc = (state == ST_IDLE) && (state_nx == ST_ARM);
  assign commit    = upd_pending && (run_sync || arm_done);

  always_comb begin
    state_nx = state;
    if (fault_s) begin
      state_nx = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE:      if (cmd_start && !cmd_stop) state_nx = ST_ARM;
        ST_ARM: begin
          if (cmd_stop)                           state_nx = ST_IDLE;
          else if (arm_cnt == AW'(ARM_CYCLES - 1)) state_nx = ST_RUN;
        end
        ST_RUN:       if (cmd_stop)   state_nx = ST_STOP_WAIT;
        ST_STOP_WAIT: if (sync_pulse) state_nx = ST_IDLE;
        ST_FAULT:     if (fault_clr)  state_nx = ST_IDLE;
        default:                      state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      arm_cnt      <= '0;
      shadow       <= DIV_W'(MIN_DIV);
      gen_freq_div <= DIV_W'(MIN_DIV);
      upd_pending  <= 1'b0;
      upd_done     <= 1'b0;
      mod_req      <= 1'b0;
      period_cnt   <= '0;
    end else begin
      state    <= state_nx;
      upd_done <= commit;
      mod_req  <= run_sync;

      if (state == ST_IDLE)     arm_cnt <= '0;
      else if (state == ST_ARM) arm_cnt <= arm_cnt + 1'b1;

      // Commit always takes the old shadow; a same-cycle write re-arms pending
      if (commit)                   gen_freq_div <= shadow;
      else if (cfg_wr && !buffered) gen_freq_div <= wr_val;

      if (cfg_wr && buffered) begin
        shadow      <= wr_val;
        upd_pending <= 1'b1;
      end else if (commit) begin
        upd_pending <= 1'b0;
      end

      if (start_acc)     period_cnt <= '0;
      else if (run_sync) period_cnt <= period_cnt + 1'b1;
    end
  end

  assign gen_enable    = run_like;
  assign fault_latched = (state == ST_FAULT);
  assign state_o       = state;
endmodule
